reg_bank_ctr: RTL and testbench

- Parametrised bank of NUM_REGS counter-registers, each WIDTH bits wide. Successor to the single 16-bit DR-style register.
- Each register supports clear, load, increment and decrement. Adds decrement, a bank-wide clear, a saturate mode, a read mux, and registered carry/zero flags.
- Sits between the datapath bus and control unit. The zero flag drives ISZ-style skip decisions in the sequencer.

---
 rtl/bc_pkg.sv | 12 +
 rtl/ctr_reg_cell.sv | 59 +++++
 rtl/reg_bank_ctr.sv | 95 +++++++++
 tb/tb_reg_bank_ctr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared defaults and helpers for the counter register bank.
package bc_pkg;

   localparam int unsigned DEF_WIDTH    = 16;
   localparam int unsigned DEF_NUM_REGS = 4;

   // Select width for an n-entry bank; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ctr_reg_cell.sv
// One WIDTH-bit counter register with clear/load/increment/decrement,
// exposing the next-state carry and zero flags for the bank to register.
module ctr_reg_cell
   import bc_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned SATURATE = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             ld,
   input  logic             inr,
   input  logic             dec,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             carry,
   output logic             zero_nxt
);

   localparam logic [WIDTH-1:0] Ones = {WIDTH{1'b1}};

   logic [WIDTH-1:0] nxt;

   always_comb begin
      nxt   = q;
      carry = 1'b0;
      if (clr) begin
         nxt = '0;
      end else if (ld) begin
         nxt = din;
      end else if (inr) begin
         if (q == Ones) begin
            carry = 1'b1;
            nxt   = (SATURATE != 0) ? q : '0;
         end else begin
            nxt = q + WIDTH'(1);
         end
      end else if (dec) begin
         if (q == '0) begin
            carry = 1'b1;
            nxt   = (SATURATE != 0) ? q : Ones;
         end else begin
            nxt = q - WIDTH'(1);
         end
      end
      // Saturating inr never produces 0, so one zero rule covers every mode.
      zero_nxt = (nxt == '0);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q <= '0;
      end else if (clr || ld || inr || dec) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/reg_bank_ctr.sv
// Bank of NUM_REGS counter registers with a combinational read mux and
// registered carry/zero/op_done flags for the last accepted operation.
module reg_bank_ctr
   import bc_pkg::*;
#(
   parameter  int unsigned WIDTH    = DEF_WIDTH,
   parameter  int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter  int unsigned SATURATE = 0,
   localparam int unsigned AW       = sel_width(NUM_REGS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr_all,
   input  logic             clr,
   input  logic             ld,
   input  logic             inr,
   input  logic             dec,
   input  logic [AW-1:0]    wr_sel,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    rd_sel,
   output logic [WIDTH-1:0] dout,
   output logic             cout,
   output logic             zero,
   output logic             op_done
);

   logic [WIDTH-1:0]    q_arr [NUM_REGS];
   logic [NUM_REGS-1:0] sel_vec;
   logic [NUM_REGS-1:0] carry_vec;
   logic [NUM_REGS-1:0] zero_vec;
   logic                any_req;
   logic                accept;
   logic                sel_carry;
   logic                sel_zero;

   assign any_req = clr | ld | inr | dec;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
      assign sel_vec[i] = (wr_sel == AW'(i));

      ctr_reg_cell #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_cell (
         .CLK      (CLK),
         .RST      (RST),
         .clr      (clr_all | (sel_vec[i] & clr)),
         .ld       (sel_vec[i] & ld),
         .inr      (sel_vec[i] & inr),
         .dec      (sel_vec[i] & dec),
         .din      (din),
         .q        (q_arr[i]),
         .carry    (carry_vec[i]),
         .zero_nxt (zero_vec[i])
      );
   end

   // An out-of-range wr_sel matches no cell, so the request is simply ignored.
   assign accept = clr_all | (any_req & (|sel_vec));

   always_comb begin
      sel_carry = 1'b0;
      sel_zero  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel_vec[i]) begin
            sel_carry = carry_vec[i];
            sel_zero  = zero_vec[i];
         end
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_sel == AW'(i)) begin
            dout = q_arr[i];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cout    <= 1'b0;
         zero    <= 1'b0;
         op_done <= 1'b0;
      end else begin
         op_done <= accept;
         if (accept) begin
            cout <= clr_all ? 1'b0 : sel_carry;
            zero <= clr_all ? 1'b1 : sel_zero;
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_ctr.sv
// Scoreboard bench: three bank variants (default, saturating, 3-entry).
module tb_reg_bank_ctr;

   typedef struct {
      int          d;
      logic        c;
      logic        z;
      logic [15:0] v;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic        clr_all_s [3];
   logic        clr_s     [3];
   logic        ld_s      [3];
   logic        inr_s     [3];
   logic        dec_s     [3];
   logic [1:0]  wr_sel_s  [3];
   logic [15:0] din_s     [3];
   logic [1:0]  rd_sel_s  [3];
   logic [15:0] dout_s    [3];
   logic        cout_s    [3];
   logic        zero_s    [3];
   logic        op_done_s [3];

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   reg_bank_ctr #(.WIDTH(16), .NUM_REGS(4), .SATURATE(0)) u_dut0 (
      .CLK(CLK), .RST(RST), .clr_all(clr_all_s[0]), .clr(clr_s[0]), .ld(ld_s[0]),
      .inr(inr_s[0]), .dec(dec_s[0]), .wr_sel(wr_sel_s[0]), .din(din_s[0]),
      .rd_sel(rd_sel_s[0]), .dout(dout_s[0]), .cout(cout_s[0]), .zero(zero_s[0]),
      .op_done(op_done_s[0])
   );

   reg_bank_ctr #(.WIDTH(16), .NUM_REGS(4), .SATURATE(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .clr_all(clr_all_s[1]), .clr(clr_s[1]), .ld(ld_s[1]),
      .inr(inr_s[1]), .dec(dec_s[1]), .wr_sel(wr_sel_s[1]), .din(din_s[1]),
      .rd_sel(rd_sel_s[1]), .dout(dout_s[1]), .cout(cout_s[1]), .zero(zero_s[1]),
      .op_done(op_done_s[1])
   );

   reg_bank_ctr #(.WIDTH(16), .NUM_REGS(3), .SATURATE(0)) u_dut2 (
      .CLK(CLK), .RST(RST), .clr_all(clr_all_s[2]), .clr(clr_s[2]), .ld(ld_s[2]),
      .inr(inr_s[2]), .dec(dec_s[2]), .wr_sel(wr_sel_s[2]), .din(din_s[2]),
      .rd_sel(rd_sel_s[2]), .dout(dout_s[2]), .cout(cout_s[2]), .zero(zero_s[2]),
      .op_done(op_done_s[2])
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every op_done pulse pops one expected result.
   always @(negedge CLK) begin
      for (int d = 0; d < 3; d++) begin
         if (op_done_s[d] === 1'b1) begin
            if (sb.size() == 0) begin
               chk($sformatf("unexpected_op_done_dut%0d", d), 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_dut_id", d, e.d);
               chk($sformatf("cout_dut%0d", d), {31'd0, cout_s[d]}, {31'd0, e.c});
               chk($sformatf("zero_dut%0d", d), {31'd0, zero_s[d]}, {31'd0, e.z});
               chk($sformatf("dout_dut%0d", d), {16'd0, dout_s[d]}, {16'd0, e.v});
            end
         end
      end
   end

   // Issue one operation, then an idle cycle so the monitor samples with rd_sel=ws.
   task automatic do_op(input int d, input logic ca, input logic c, input logic l,
                        input logic i, input logic de, input logic [1:0] ws,
                        input logic [15:0] dn, input bit has_exp, input logic ec,
                        input logic ez, input logic [15:0] ev, input bit pre_chk,
                        input logic [15:0] pre_val);
      clr_all_s[d] = ca;
      clr_s[d]     = c;
      ld_s[d]      = l;
      inr_s[d]     = i;
      dec_s[d]     = de;
      wr_sel_s[d]  = ws;
      din_s[d]     = dn;
      rd_sel_s[d]  = ws;
      if (has_exp) sb.push_back('{d: d, c: ec, z: ez, v: ev});
      if (pre_chk) begin
         #1;
         chk("read_during_write_pre", {16'd0, dout_s[d]}, {16'd0, pre_val});
      end
      @(posedge CLK);
      #1;
      clr_all_s[d] = 1'b0;
      clr_s[d]     = 1'b0;
      ld_s[d]      = 1'b0;
      inr_s[d]     = 1'b0;
      dec_s[d]     = 1'b0;
      if (!has_exp) chk("op_done_low_rejected", {31'd0, op_done_s[d]}, 32'd0);
      @(posedge CLK);
      #1;
   endtask

   task automatic rd(input int d, input logic [1:0] sel, input logic [15:0] ev,
                     input string name);
      rd_sel_s[d] = sel;
      @(negedge CLK);
      chk(name, {16'd0, dout_s[d]}, {16'd0, ev});
      @(posedge CLK);
      #1;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         clr_all_s[d] = 0; clr_s[d] = 0; ld_s[d] = 0; inr_s[d] = 0; dec_s[d] = 0;
         wr_sel_s[d] = 0; din_s[d] = 0; rd_sel_s[d] = 0;
      end
      RST = 1'b1;
      #12;
      chk("reset_dout", {16'd0, dout_s[0]}, 32'd0);
      chk("reset_flags", {29'd0, cout_s[0], zero_s[0], op_done_s[0]}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      // Default bank: wrap, priority, read-during-write, isolation.
      do_op(0, 0, 0, 1, 0, 0, 2'd1, 16'hFFFF, 1, 0, 0, 16'hFFFF, 0, 0);
      do_op(0, 0, 0, 0, 1, 0, 2'd1, 16'h0000, 1, 1, 1, 16'h0000, 0, 0);
      do_op(0, 0, 0, 1, 1, 0, 2'd3, 16'h00A5, 1, 0, 0, 16'h00A5, 0, 0);
      do_op(0, 0, 1, 1, 0, 0, 2'd3, 16'h5555, 1, 0, 1, 16'h0000, 0, 0);
      do_op(0, 0, 0, 1, 0, 0, 2'd0, 16'h7777, 1, 0, 0, 16'h7777, 0, 0);
      do_op(0, 0, 0, 1, 0, 0, 2'd2, 16'h0001, 1, 0, 0, 16'h0001, 0, 0);
      do_op(0, 0, 0, 0, 0, 1, 2'd2, 16'h0000, 1, 0, 1, 16'h0000, 1, 16'h0001);
      rd(0, 2'd0, 16'h7777, "isolation_r0");
      rd(0, 2'd1, 16'h0000, "isolation_r1");
      rd(0, 2'd3, 16'h0000, "isolation_r3");
      do_op(0, 0, 0, 0, 0, 1, 2'd1, 16'h0000, 1, 1, 0, 16'hFFFF, 0, 0);
      do_op(0, 0, 0, 0, 1, 0, 2'd0, 16'h0000, 1, 0, 0, 16'h7778, 0, 0);

      // Asynchronous reset mid-cycle with live flags and data.
      do_op(0, 0, 0, 1, 0, 0, 2'd2, 16'h1234, 1, 0, 0, 16'h1234, 0, 0);
      do_op(0, 0, 0, 0, 1, 0, 2'd1, 16'h0000, 1, 1, 1, 16'h0000, 0, 0);
      rd_sel_s[0] = 2'd2;
      #2;
      RST = 1'b1;
      #1;
      chk("async_reset_dout", {16'd0, dout_s[0]}, 32'd0);
      chk("async_reset_flags", {29'd0, cout_s[0], zero_s[0], op_done_s[0]}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      rd(0, 2'd0, 16'h0000, "post_reset_r0");

      // Saturating bank.
      do_op(1, 0, 0, 1, 0, 0, 2'd0, 16'hFFFF, 1, 0, 0, 16'hFFFF, 0, 0);
      do_op(1, 0, 0, 0, 1, 0, 2'd0, 16'h0000, 1, 1, 0, 16'hFFFF, 0, 0);
      do_op(1, 0, 0, 1, 0, 0, 2'd0, 16'h0000, 1, 0, 1, 16'h0000, 0, 0);
      do_op(1, 0, 0, 0, 0, 1, 2'd0, 16'h0000, 1, 1, 1, 16'h0000, 0, 0);
      do_op(1, 0, 0, 1, 0, 0, 2'd1, 16'h0005, 1, 0, 0, 16'h0005, 0, 0);
      do_op(1, 0, 0, 0, 0, 1, 2'd1, 16'h0000, 1, 0, 0, 16'h0004, 0, 0);
      do_op(1, 0, 0, 1, 0, 0, 2'd1, 16'h0001, 1, 0, 0, 16'h0001, 0, 0);
      do_op(1, 0, 0, 0, 0, 1, 2'd1, 16'h0000, 1, 0, 1, 16'h0000, 0, 0);
      do_op(1, 0, 0, 0, 1, 0, 2'd1, 16'h0000, 1, 0, 0, 16'h0001, 0, 0);

      // Three-entry bank: out-of-range select, then clr_all.
      do_op(2, 0, 0, 1, 0, 0, 2'd2, 16'hABCD, 1, 0, 0, 16'hABCD, 0, 0);
      do_op(2, 0, 0, 1, 0, 0, 2'd0, 16'h0000, 1, 0, 1, 16'h0000, 0, 0);
      do_op(2, 0, 0, 0, 0, 1, 2'd0, 16'h0000, 1, 1, 0, 16'hFFFF, 0, 0);
      do_op(2, 0, 0, 1, 0, 0, 2'd3, 16'h1234, 0, 0, 0, 16'h0000, 0, 0);
      chk("oor_flags_hold", {30'd0, cout_s[2], zero_s[2]}, 32'd2);
      rd(2, 2'd3, 16'h0000, "oor_read_zero");
      rd(2, 2'd2, 16'hABCD, "oor_r2_unchanged");
      rd(2, 2'd0, 16'hFFFF, "oor_r0_unchanged");
      do_op(2, 1, 0, 0, 0, 0, 2'd2, 16'h0000, 1, 0, 1, 16'h0000, 0, 0);
      rd(2, 2'd0, 16'h0000, "clr_all_r0");
      rd(2, 2'd1, 16'h0000, "clr_all_r1");

      repeat (3) @(posedge CLK);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
